// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg: shared types and defaults for the frame streamer.
// Holds the FSM state encoding, default geometry and the pixel width.
package frame_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int DEF_HRES       = 1280;
    localparam int DEF_VRES       = 720;
    localparam int DEF_HGAP       = 16;
    localparam int DEF_RD_LATENCY = 2;
    localparam int PIXEL_W        = 16;

endpackage

// File: rtl/frame_streamer_valid_pipe.sv
// valid_pipe: DEPTH-stage shift register of W-bit entries, cleared by rst_in.
// Ports: clk_in, rst_in, d_in (entry, MSB = valid), q_out (tail), any_valid_out.
module valid_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out,
    output logic         any_valid_out
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // MSB of every entry is its valid bit
    always_comb begin
        any_valid_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid_out = any_valid_out | stage_q[i][W-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: raster-scans a frame buffer BRAM and emits a pixel stream.
// Ports: clk_in, rst_in, start_in, addr_out/rd_data_in (BRAM), data_valid_out,
//   pixel_data_out, hcount_out, vcount_out, busy_out, frame_done_out.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int HRES       = DEF_HRES,
    parameter int VRES       = DEF_VRES,
    parameter int HGAP       = DEF_HGAP,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    localparam int AW = (HRES * VRES > 1) ? $clog2(HRES * VRES) : 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    output logic [AW-1:0]      addr_out,
    input  logic [PIXEL_W-1:0] rd_data_in,
    output logic               data_valid_out,
    output logic [PIXEL_W-1:0] pixel_data_out,
    output logic [10:0]        hcount_out,
    output logic [9:0]         vcount_out,
    output logic               busy_out,
    output logic               frame_done_out
);

    localparam int HW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int VW = (VRES > 1) ? $clog2(VRES) : 1;
    localparam int GW = (HGAP > 1) ? $clog2(HGAP) : 1;
    localparam int PW = 1 + HW + VW;

    state_e state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;

    logic               dv_q, dv_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic [10:0]        hc_q, hc_d;
    logic [9:0]         vc_q, vc_d;

    logic          issue;
    logic          h_last, v_last, gap_last;
    logic [PW-1:0] pipe_in, pipe_tail;
    logic          pipe_busy;
    logic          tail_vld;
    logic [HW-1:0] tail_h;
    logic [VW-1:0] tail_v;

    assign h_last   = (h_q == HW'(HRES - 1));
    assign v_last   = (v_q == VW'(VRES - 1));
    assign gap_last = (gap_q == GW'(HGAP - 1));

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = ACTIVE;
                    h_d     = '0;
                    v_d     = '0;
                    addr_d  = '0;
                end
            end
            ACTIVE: begin
                issue  = 1'b1;
                hold_d = addr_q;
                if (h_last) begin
                    h_d = '0;
                    if (v_last) begin
                        // address stays at the final pixel; no wrap
                        state_d = DRAIN;
                    end else begin
                        v_d    = v_q + VW'(1);
                        addr_d = addr_q + AW'(1);
                        if (HGAP != 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end
                end else begin
                    h_d    = h_q + HW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_d = ACTIVE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_d  = (state_q == DRAIN) && !pipe_busy;
    assign pipe_in = {issue, h_q, v_q};

    valid_pipe #(
        .W     (PW),
        .DEPTH (RD_LATENCY)
    ) u_pipe (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .d_in          (pipe_in),
        .q_out         (pipe_tail),
        .any_valid_out (pipe_busy)
    );

    assign tail_vld = pipe_tail[PW-1];
    assign tail_h   = pipe_tail[HW+VW-1:VW];
    assign tail_v   = pipe_tail[VW-1:0];

    // payload holds while invalid
    always_comb begin
        dv_d  = tail_vld;
        pix_d = pix_q;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (tail_vld) begin
            pix_d = rd_data_in;
            hc_d  = 11'(tail_h);
            vc_d  = 10'(tail_v);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            pix_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
            pix_q   <= pix_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
        end
    end

    // live counter while reading, last issued address otherwise
    assign addr_out       = (state_q == ACTIVE) ? addr_q : hold_q;
    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = done_q;
    assign data_valid_out = dv_q;
    assign pixel_data_out = pix_q;
    assign hcount_out     = hc_q;
    assign vcount_out     = vc_q;

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: scoreboard bench for three frame_streamer geometries.
// u0 = 4x3 gap 2, u1 = 4x3 gap 0, u2 = 1x1; BRAM models return pixel = addr.
module tb_frame_streamer;

    localparam int CFG_H [3] = '{4, 4, 1};
    localparam int CFG_V [3] = '{3, 3, 1};
    localparam int CFG_G [3] = '{2, 0, 2};

    localparam int K_PIX  = 0;
    localparam int K_ADDR = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int k;
        int kind;
        int cyc;
        int val;
        int h;
        int v;
    } ent_t;

    logic        clk = 1'b0;
    logic        start_s [3];
    logic        rst_s   [3];
    logic [3:0]  addr0, addr1;
    logic [0:0]  addr2;
    logic [31:0] addr_w  [3];
    logic [15:0] rd      [3];
    logic [15:0] r1      [3];
    logic        dv      [3];
    logic [15:0] pix     [3];
    logic [10:0] hc      [3];
    logic [9:0]  vc      [3];
    logic        busy    [3];
    logic        done    [3];

    ent_t sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_addr [3];
    int   last_pix  [3];
    int   last_h    [3];
    int   last_v    [3];

    always #5 clk = ~clk;

    assign addr_w[0] = 32'(addr0);
    assign addr_w[1] = 32'(addr1);
    assign addr_w[2] = 32'(addr2);

    // two-cycle read latency BRAM, contents = address
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            r1[k] <= 16'(addr_w[k]);
            rd[k] <= r1[k];
        end
    end

    frame_streamer #(.HRES(4), .VRES(3), .HGAP(2), .RD_LATENCY(2)) u0 (
        .clk_in(clk), .rst_in(rst_s[0]), .start_in(start_s[0]),
        .addr_out(addr0), .rd_data_in(rd[0]), .data_valid_out(dv[0]),
        .pixel_data_out(pix[0]), .hcount_out(hc[0]), .vcount_out(vc[0]),
        .busy_out(busy[0]), .frame_done_out(done[0])
    );

    frame_streamer #(.HRES(4), .VRES(3), .HGAP(0), .RD_LATENCY(2)) u1 (
        .clk_in(clk), .rst_in(rst_s[1]), .start_in(start_s[1]),
        .addr_out(addr1), .rd_data_in(rd[1]), .data_valid_out(dv[1]),
        .pixel_data_out(pix[1]), .hcount_out(hc[1]), .vcount_out(vc[1]),
        .busy_out(busy[1]), .frame_done_out(done[1])
    );

    frame_streamer #(.HRES(1), .VRES(1), .HGAP(2), .RD_LATENCY(2)) u2 (
        .clk_in(clk), .rst_in(rst_s[2]), .start_in(start_s[2]),
        .addr_out(addr2), .rd_data_in(rd[2]), .data_valid_out(dv[2]),
        .pixel_data_out(pix[2]), .hcount_out(hc[2]), .vcount_out(vc[2]),
        .busy_out(busy[2]), .frame_done_out(done[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int k, input int c0);
        int h;
        int v;
        int g;
        int iss;
        int dn;
        h = CFG_H[k];
        v = CFG_V[k];
        g = CFG_G[k];
        for (int r = 0; r < v; r++) begin
            for (int c = 0; c < h; c++) begin
                iss = c0 + 1 + r * (h + g) + c;
                sb.push_back('{k, K_ADDR, iss, r * h + c, 0, 0});
                sb.push_back('{k, K_PIX, iss + 3, r * h + c, c, r});
            end
        end
        dn = c0 + 1 + v * h + (v - 1) * g + 3;
        sb.push_back('{k, K_DONE, dn, 1, 0, 0});
        for (int c = c0 + 1; c < dn; c++) begin
            sb.push_back('{k, K_BUSY, c, 1, 0, 0});
        end
    endtask

    task automatic take(input int k, input int kind, output bit hit,
                        output ent_t e);
        hit = 1'b0;
        e   = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < sb.size(); i++) begin
            if (!hit && sb[i].k == k && sb[i].kind == kind
                && sb[i].cyc == cyc) begin
                e   = sb[i];
                hit = 1'b1;
                sb.delete(i);
            end
        end
    endtask

    task automatic flush(input int k, input int c);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].k == k && sb[i].cyc > c) sb.delete(i);
        end
        last_addr[k] = 0;
        last_pix[k]  = 0;
        last_h[k]    = 0;
        last_v[k]    = 0;
    endtask

    task automatic check_cycle();
        bit   hit;
        ent_t e;
        for (int k = 0; k < 3; k++) begin
            take(k, K_ADDR, hit, e);
            if (hit) last_addr[k] = e.val;
            chk($sformatf("u%0d addr c%0d", k, cyc), addr_w[k], last_addr[k]);
            take(k, K_PIX, hit, e);
            chk($sformatf("u%0d valid c%0d", k, cyc), 32'(dv[k]), 32'(hit));
            if (hit) begin
                last_pix[k] = e.val;
                last_h[k]   = e.h;
                last_v[k]   = e.v;
            end
            chk($sformatf("u%0d pixel c%0d", k, cyc), 32'(pix[k]), last_pix[k]);
            chk($sformatf("u%0d hcount c%0d", k, cyc), 32'(hc[k]), last_h[k]);
            chk($sformatf("u%0d vcount c%0d", k, cyc), 32'(vc[k]), last_v[k]);
            take(k, K_BUSY, hit, e);
            chk($sformatf("u%0d busy c%0d", k, cyc), 32'(busy[k]), 32'(hit));
            take(k, K_DONE, hit, e);
            chk($sformatf("u%0d done c%0d", k, cyc), 32'(done[k]), 32'(hit));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int base;
        for (int k = 0; k < 3; k++) begin
            start_s[k]   = 1'b0;
            rst_s[k]     = 1'b1;
            last_addr[k] = 0;
            last_pix[k]  = 0;
            last_h[k]    = 0;
            last_v[k]    = 0;
        end
        run(2);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        tick();

        // plain frame on all three geometries
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b1;
            push_frame(k, base);
        end
        tick();
        for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
        run(24);

        // start re-asserted mid-frame is ignored
        base = cyc;
        start_s[0] = 1'b1;
        push_frame(0, base);
        tick();
        start_s[0] = 1'b0;
        run(5);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        run(18);

        // reset in row 1, then a fresh frame
        base = cyc;
        start_s[0] = 1'b1;
        push_frame(0, base);
        tick();
        start_s[0] = 1'b0;
        run(7);
        rst_s[0] = 1'b1;
        flush(0, base + 8);
        tick();
        rst_s[0] = 1'b0;
        run(3);
        start_s[0] = 1'b1;
        push_frame(0, base + 12);
        tick();
        start_s[0] = 1'b0;
        run(25);

        // start held high: back-to-back frames from the done cycle
        base = cyc;
        start_s[0] = 1'b1;
        push_frame(0, base);
        push_frame(0, base + 20);
        run(21);
        start_s[0] = 1'b0;
        run(24);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
